// File: rtl/pipelined_adder.sv
// pipelined_adder: WIDTH-bit adder with carry-in, split into STAGES carry-chunked stages
// behind a valid/ready handshake, reporting carry-out and signed overflow.
module pipelined_adder #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);
    localparam int CHUNK = WIDTH / STAGES;

    if (WIDTH < 1 || STAGES < 1 || STAGES > WIDTH || WIDTH % STAGES != 0) begin : g_bad_params
        $error("pipelined_adder: need WIDTH >= 1, 1 <= STAGES <= WIDTH, WIDTH %% STAGES == 0");
    end

    logic [STAGES-1:0] v, c, xv, xc, nc;
    logic [WIDTH-1:0]  ra [STAGES];
    logic [WIDTH-1:0]  rb [STAGES];
    logic [WIDTH-1:0]  rs [STAGES];
    logic [WIDTH-1:0]  xa [STAGES];
    logic [WIDTH-1:0]  xb [STAGES];
    logic [WIDTH-1:0]  xs [STAGES];
    logic [WIDTH-1:0]  ns [STAGES];
    logic [CHUNK:0]    t;
    logic              adv;

    assign adv       = !v[STAGES-1] || out_ready;
    assign in_ready  = adv;
    assign out_valid = v[STAGES-1];
    assign sum       = rs[STAGES-1];
    assign cout      = c[STAGES-1];
    assign overflow  = (ra[STAGES-1][WIDTH-1] == rb[STAGES-1][WIDTH-1]) &&
                       (rs[STAGES-1][WIDTH-1] != ra[STAGES-1][WIDTH-1]);

    // Stage k sees the previous stage's registers; stage 0 sees the ports.
    always_comb begin
        t     = '0;
        xa[0] = a;
        xb[0] = b;
        xs[0] = '0;
        xc[0] = cin;
        xv[0] = in_valid;
        for (int k = 1; k < STAGES; k++) begin
            xa[k] = ra[k-1];
            xb[k] = rb[k-1];
            xs[k] = rs[k-1];
            xc[k] = c[k-1];
            xv[k] = v[k-1];
        end
        for (int k = 0; k < STAGES; k++) begin
            t     = {1'b0, CHUNK'(xa[k] >> (k * CHUNK))} +
                    {1'b0, CHUNK'(xb[k] >> (k * CHUNK))} + (CHUNK + 1)'(xc[k]);
            ns[k] = xs[k] | (WIDTH'(t[CHUNK-1:0]) << (k * CHUNK));
            nc[k] = t[CHUNK];
        end
    end

    // Data only loads behind a valid bit, so bubbles leave the outputs untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            v <= '0;
            c <= '0;
            for (int k = 0; k < STAGES; k++) begin
                ra[k] <= '0;
                rb[k] <= '0;
                rs[k] <= '0;
            end
        end else if (adv) begin
            v <= xv;
            for (int k = 0; k < STAGES; k++) begin
                if (xv[k]) begin
                    ra[k] <= xa[k];
                    rb[k] <= xb[k];
                    rs[k] <= ns[k];
                    c[k]  <= nc[k];
                end
            end
        end
    end
endmodule

// File: tb/tb_pipelined_adder.sv
// tb_pipelined_adder: directed checks of three adder configurations
// (16/4, 16/1, 8/8) driven from shared stimulus.
module tb_pipelined_adder;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic        cin = 1'b0;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic [2:0]  ov, ir, co, of;
    logic [15:0] os [3];
    logic [7:0]  s2;
    int          checks = 0;
    int          failures = 0;
    localparam int LAT [3] = '{4, 1, 8};

    always #5 clk = ~clk;

    pipelined_adder #(.WIDTH(16), .STAGES(4)) u0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[0]), .a(a), .b(b), .cin(cin),
        .out_valid(ov[0]), .out_ready(out_ready), .sum(os[0]), .cout(co[0]), .overflow(of[0]));
    pipelined_adder #(.WIDTH(16), .STAGES(1)) u1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[1]), .a(a), .b(b), .cin(cin),
        .out_valid(ov[1]), .out_ready(out_ready), .sum(os[1]), .cout(co[1]), .overflow(of[1]));
    pipelined_adder #(.WIDTH(8), .STAGES(8)) u2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[2]), .a(a[7:0]), .b(b[7:0]), .cin(cin),
        .out_valid(ov[2]), .out_ready(out_ready), .sum(s2), .cout(co[2]), .overflow(of[2]));

    assign os[2] = {8'h00, s2};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // One isolated op into all three DUTs; each must produce it once, at its latency.
    task automatic run_one(input string tag, input logic [15:0] va, input logic [15:0] vb,
                           input logic vc, input logic [15:0] es, input logic ec, input logic eo,
                           input logic [7:0] es8, input logic ec8, input logic eo8);
        int          cnt [3];
        int          at [3];
        logic [15:0] gs [3];
        logic        gc [3];
        logic        go [3];
        logic [15:0] xs [3];
        logic        xc [3];
        logic        xo [3];
        xs[0] = es; xs[1] = es; xs[2] = {8'h00, es8};
        xc[0] = ec; xc[1] = ec; xc[2] = ec8;
        xo[0] = eo; xo[1] = eo; xo[2] = eo8;
        for (int d = 0; d < 3; d++) begin
            cnt[d] = 0; at[d] = 0; gs[d] = '0; gc[d] = 1'b0; go[d] = 1'b0;
        end
        @(negedge clk);
        a = va; b = vb; cin = vc; in_valid = 1'b1; out_ready = 1'b1;
        for (int n = 1; n <= 12; n++) begin
            @(negedge clk);
            in_valid = 1'b0;
            #1;
            for (int d = 0; d < 3; d++) begin
                if (ov[d]) begin
                    if (cnt[d] == 0) begin
                        at[d] = n; gs[d] = os[d]; gc[d] = co[d]; go[d] = of[d];
                    end
                    cnt[d]++;
                end
            end
        end
        for (int d = 0; d < 3; d++) begin
            check($sformatf("%s_u%0d_count", tag, d), cnt[d], 1);
            check($sformatf("%s_u%0d_latency", tag, d), at[d], LAT[d]);
            check($sformatf("%s_u%0d_sum", tag, d), gs[d], xs[d]);
            check($sformatf("%s_u%0d_cout", tag, d), gc[d], xc[d]);
            check($sformatf("%s_u%0d_ovf", tag, d), go[d], xo[d]);
        end
    endtask

    logic [15:0] exp_s [8] = '{16'h0F0F, 16'h2021, 16'h3131, 16'h4243,
                               16'h5353, 16'h6465, 16'h7575, 16'h8687};
    logic        exp_o [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    initial begin
        int issued, rcv, stall, last, seen;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        for (int d = 0; d < 3; d++) begin
            check($sformatf("reset_u%0d_valid", d), ov[d], 0);
            check($sformatf("reset_u%0d_sum", d), os[d], 0);
            check($sformatf("reset_u%0d_in_ready", d), ir[d], 1);
        end

        run_one("zero",   16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        run_one("ripple", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
        run_one("ovf16",  16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0);
        run_one("max",    16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0);
        run_one("ovf8",   16'h007F, 16'h0001, 1'b0, 16'h0080, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);

        // Streaming with a 3-cycle consumer stall after the second result (checked on u0).
        issued = 0; rcv = 0; stall = 0; last = 0;
        for (int cyc = 0; cyc < 60 && rcv < 8; cyc++) begin
            @(negedge clk);
            out_ready = (stall == 0);
            if (stall > 0) stall--;
            in_valid = (issued < 8);
            a = 16'(issued * 16'h1111);
            b = 16'h0F0F;
            cin = 1'(issued & 1);
            #1;
            if (!out_ready) begin
                check("stall_in_ready", ir[0], 0);
                check("stall_valid", ov[0], 1);
                check("stall_sum", os[0], exp_s[rcv]);
            end
            if (ov[0] && out_ready) begin
                check($sformatf("stream%0d_sum", rcv), os[0], exp_s[rcv]);
                check($sformatf("stream%0d_cout", rcv), co[0], 0);
                check($sformatf("stream%0d_ovf", rcv), of[0], exp_o[rcv]);
                if (rcv > 0) check($sformatf("stream%0d_gap", rcv), cyc - last, (rcv == 2) ? 4 : 1);
                last = cyc;
                rcv++;
                if (rcv == 2) stall = 3;
            end
            if (in_valid && ir[0]) issued++;
        end
        check("stream_count", rcv, 8);

        // Reset with three ops in flight: none may surface.
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (10) @(negedge clk);
        in_valid = 1'b1; a = 16'hAAAA; b = 16'h1111; cin = 1'b0;
        @(negedge clk);
        a = 16'hBBBB;
        @(negedge clk);
        a = 16'hCCCC;
        @(negedge clk);
        in_valid = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        for (int d = 0; d < 3; d++) begin
            check($sformatf("flush_u%0d_valid", d), ov[d], 0);
            check($sformatf("flush_u%0d_sum", d), os[d], 0);
        end
        seen = 0;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            #1;
            if (ov[0]) seen++;
        end
        check("flush_none_appear", seen, 0);
        run_one("post_rst", 16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0, 8'h56, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
